// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a requester and mem_responder.
// Request side carries a byte address and write data; response side returns data and status.
interface mem_responder_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] addressInput;
  logic [31:0] writeData;
  logic        respValid;
  logic        respReady;
  logic [31:0] readData;
  logic        respError;

  modport master (
    output reqValid,
    output reqWrite,
    output addressInput,
    output writeData,
    output respReady,
    input  reqReady,
    input  respValid,
    input  readData,
    input  respError
  );

  modport slave (
    input  reqValid,
    input  reqWrite,
    input  addressInput,
    input  writeData,
    input  respReady,
    output reqReady,
    output respValid,
    output readData,
    output respError
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word-addressed RAM behind a ready/valid request/response port.
// One transaction in flight; misaligned or out-of-range accesses report an error.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_write;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_access;
  logic          w_done;
  logic          w_bad;
  logic          w_wr_en;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_hi;

  assign w_accept = (r_state == S_IDLE) && bus.reqValid;
  assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_done   = (r_state == S_RESP) && bus.respReady;

  // Bits above the array's word index must be zero to be in range.
  assign w_idx   = r_addr[AW+1:2];
  assign w_hi    = r_addr >> (AW + 2);
  assign w_bad   = (r_addr[1:0] != 2'b00) || (w_hi != '0);
  assign w_wr_en = w_access && r_write && !w_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == S_IDLE): if (bus.reqValid)  w_next = S_WAIT;
      (r_state == S_WAIT): if (r_cnt == '0)   w_next = S_RESP;
      (r_state == S_RESP): if (bus.respReady) w_next = S_IDLE;
      default:                                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.reqReady  = 1'b0;
    bus.respValid = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): bus.reqReady  = 1'b1;
      (r_state == S_RESP): bus.respValid = 1'b1;
      default: ;
    endcase
    bus.readData  = r_rdata;
    bus.respError = r_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CNT_LOAD;
      r_addr  <= bus.addressInput;
      r_wdata <= bus.writeData;
      r_write <= bus.reqWrite;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err   <= w_bad;
      r_rdata <= (!r_write && !w_bad) ? r_mem[w_idx] : 32'h0;
    end else if (w_done) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  // Array is deliberately unreset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= r_wdata;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY 2, 3 and 1.
// One request bus is steered to the instance picked by sel.
module tb_mem_responder;
  logic        clk;
  logic        rst2, rst3, rst1;
  logic [1:0]  sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_ready;

  logic        obs_ready;
  logic        obs_valid;
  logic [31:0] obs_rdata;
  logic        obs_err;

  int checks;
  int passes;

  mem_responder_if if2();
  mem_responder_if if3();
  mem_responder_if if1();

  assign if2.reqValid     = req_valid && (sel == 2'd0);
  assign if3.reqValid     = req_valid && (sel == 2'd1);
  assign if1.reqValid     = req_valid && (sel == 2'd2);
  assign if2.reqWrite     = req_write;
  assign if3.reqWrite     = req_write;
  assign if1.reqWrite     = req_write;
  assign if2.addressInput = addr;
  assign if3.addressInput = addr;
  assign if1.addressInput = addr;
  assign if2.writeData    = wdata;
  assign if3.writeData    = wdata;
  assign if1.writeData    = wdata;
  assign if2.respReady    = resp_ready && (sel == 2'd0);
  assign if3.respReady    = resp_ready && (sel == 2'd1);
  assign if1.respReady    = resp_ready && (sel == 2'd2);

  mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk (clk),
    .rst (rst2),
    .bus (if2)
  );

  mem_responder #(.DEPTH(256), .LATENCY(3)) u_l3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3)
  );

  mem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  always_comb begin
    obs_ready = 1'b0;
    obs_valid = 1'b0;
    obs_rdata = '0;
    obs_err   = 1'b0;
    case (sel)
      2'd0: begin
        obs_ready = if2.reqReady;
        obs_valid = if2.respValid;
        obs_rdata = if2.readData;
        obs_err   = if2.respError;
      end
      2'd1: begin
        obs_ready = if3.reqReady;
        obs_valid = if3.respValid;
        obs_rdata = if3.readData;
        obs_err   = if3.respError;
      end
      default: begin
        obs_ready = if1.reqReady;
        obs_valid = if1.respValid;
        obs_rdata = if1.readData;
        obs_err   = if1.respError;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".reqReady"},  32'(obs_ready), 32'd1);
    chk({tag, ".respValid"}, 32'(obs_valid), 32'd0);
    chk({tag, ".readData"},  obs_rdata,      32'h0);
    chk({tag, ".respError"}, 32'(obs_err),   32'd0);
  endtask

  // Issue one request and return edges from acceptance to respValid.
  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    int n;
    n = 0;
    while (!obs_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req.ready_timeout", 32'(obs_ready), 32'd1);
    req_write = w;
    addr      = a;
    wdata     = d;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    addr      = 32'hFFFF_FFFF;
    wdata     = 32'h0BAD_0BAD;
    req_write = ~w;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (obs_valid) break;
    end
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk_idle(tag);
  endtask

  int lat;
  int acc_idx[$];
  int rsp_idx[$];
  logic [31:0] rsp_dat[$];

  initial begin
    checks     = 0;
    passes     = 0;
    sel        = 2'd0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    addr       = '0;
    wdata      = '0;
    resp_ready = 1'b0;
    rst2 = 1'b0;
    rst3 = 1'b0;
    rst1 = 1'b0;

    repeat (2) @(negedge clk);
    chk_idle("reset.during");
    rst2 = 1'b1;
    rst3 = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);
    chk_idle("reset.after");

    do_req(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, lat);
    chk("wr.latency", 32'(lat), 32'd2);
    chk("wr.readData", obs_rdata, 32'h0);
    chk("wr.respError", 32'(obs_err), 32'd0);
    handshake("wr.done");

    do_req(1'b0, 32'h0000_000C, 32'h0, lat);
    chk("rd.latency", 32'(lat), 32'd2);
    chk("rd.readData", obs_rdata, 32'hDEAD_BEEF);
    chk("rd.respError", 32'(obs_err), 32'd0);
    handshake("rd.done");

    do_req(1'b0, 32'h0000_000C, 32'h0, lat);
    chk("bp.latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 1) || (i == 2);
      req_write = 1'b1;
      addr      = 32'h0000_000C;
      wdata     = 32'h5555_AAAA;
      chk("bp.reqReady", 32'(obs_ready), 32'd0);
      @(negedge clk);
      chk("bp.respValid", 32'(obs_valid), 32'd1);
      chk("bp.readData", obs_rdata, 32'hDEAD_BEEF);
    end
    req_valid = 1'b0;
    handshake("bp.done");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp.no_phantom", 32'(obs_valid), 32'd0);
    end
    do_req(1'b0, 32'h0000_000C, 32'h0, lat);
    chk("bp.mem_intact", obs_rdata, 32'hDEAD_BEEF);
    handshake("bp.reread");

    do_req(1'b1, 32'h0000_0000, 32'h1111_2222, lat);
    handshake("err.seed");
    do_req(1'b0, 32'h0000_000F, 32'h0, lat);
    chk("err.mis.respError", 32'(obs_err), 32'd1);
    chk("err.mis.readData", obs_rdata, 32'h0);
    handshake("err.mis.done");
    do_req(1'b1, 32'h0000_0400, 32'hFFFF_FFFF, lat);
    chk("err.oor.latency", 32'(lat), 32'd2);
    chk("err.oor.respError", 32'(obs_err), 32'd1);
    chk("err.oor.readData", obs_rdata, 32'h0);
    handshake("err.oor.done");
    do_req(1'b0, 32'h0000_0000, 32'h0, lat);
    chk("err.word0", obs_rdata, 32'h1111_2222);
    chk("err.word0.respError", 32'(obs_err), 32'd0);
    handshake("err.word0.done");

    sel = 2'd1;
    @(negedge clk);
    do_req(1'b1, 32'h0000_0008, 32'hAAAA_5555, lat);
    chk("l3.latency", 32'(lat), 32'd3);
    handshake("l3.seed");
    chk("l3.ready", 32'(obs_ready), 32'd1);
    req_write = 1'b1;
    addr      = 32'h0000_0008;
    wdata     = 32'h1234_5678;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("l3.in_wait", 32'(obs_ready), 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    chk_idle("l3.async_reset");
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h0000_0008, 32'h0, lat);
    chk("l3.old_value", obs_rdata, 32'hAAAA_5555);
    handshake("l3.read.done");

    sel = 2'd2;
    @(negedge clk);
    resp_ready = 1'b1;
    req_write  = 1'b1;
    addr       = 32'h0000_0020;
    wdata      = 32'hCAFE_F00D;
    req_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (obs_valid) begin
        rsp_idx.push_back(i);
        rsp_dat.push_back(obs_rdata);
      end
      if (obs_ready) acc_idx.push_back(i);
      @(negedge clk);
      if (acc_idx.size() == 1) req_write = 1'b0;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    chk("b2b.acc_count", 32'(acc_idx.size()), 32'd4);
    chk("b2b.rsp_count", 32'(rsp_idx.size()), 32'd4);
    if (acc_idx.size() >= 3 && rsp_idx.size() >= 2) begin
      chk("b2b.acc0", 32'(acc_idx[0]), 32'd0);
      chk("b2b.gap01", 32'(acc_idx[1] - acc_idx[0]), 32'd3);
      chk("b2b.gap12", 32'(acc_idx[2] - acc_idx[1]), 32'd3);
      chk("b2b.rsp0_time", 32'(rsp_idx[0]), 32'd2);
      chk("b2b.wr_data", rsp_dat[0], 32'h0);
      chk("b2b.rd_data", rsp_dat[1], 32'hCAFE_F00D);
    end else begin
      chk("b2b.queues_short", 32'(acc_idx.size() + rsp_idx.size()), 32'd8);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the address path driven by the MAR: accepts single-word read/write requests carrying a 32-bit byte address, models a fixed-latency word-addressed RAM, and returns read data with a completion status. It sits between the MAR/MDR pair and the backing store, and gives the CPU datapath a ready/valid handshake on both the request and response sides. Exactly one transaction is outstanding at a time.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two, at least 2.
- LATENCY, 2, cycles from request acceptance to response valid; must be at least 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset).
- reqValid  in  1  request present.
- reqReady  out  1  responder can accept a request.
- reqWrite  in  1  1 = write, 0 = read.
- addressInput  in  32  byte address, from the MAR output.
- writeData  in  32  write data, from the MDR.
- respValid  out  1  response present.
- respReady  in  1  consumer accepts the response.
- readData  out  32  read result; 0 for writes and errors.
- respError  out  1  request was misaligned or out of range.

## Operation
- State machine: IDLE, WAIT, RESP.
- **IDLE**
  - reqReady=1, respValid=0.
  - On reqValid&&reqReady: latch addressInput, reqWrite and writeData into internal registers.
  - Load the latency counter with LATENCY-1 and go to WAIT.
- **WAIT**
  - reqReady=0.
  - At each edge, if the counter is nonzero, decrement it.
  - If the counter is 0, perform the access using the latched values and go to RESP.
- **RESP**
  - reqReady=0, respValid=1.
  - readData and respError stay stable until the handshake.
  - On respReady, clear respValid, readData and respError to 0 and go to IDLE.
- Input changes after acceptance (address, data, write flag) have no effect on the in-flight transaction.
- Word index = latched address[log2(DEPTH)+1:2].
- Error when address[1:0] != 0 or address[31:log2(DEPTH)+2] != 0.
  - respError=1 and readData=0.
  - Memory is not modified.
- Read with no error: readData = mem[index].
- Write with no error: mem[index] = writeData and readData=0.
- Memory contents are not reset; they are undefined until written.

## Timing
- Reset values: state IDLE, reqReady=1, respValid=0, readData=32'h0, respError=0, counter 0.
- Request accepted at edge N: respValid rises after edge N+LATENCY.
  - With LATENCY=1, respValid is high in the cycle after the acceptance cycle.
- A write commits to the array on the same edge that enters RESP. A read issued afterwards observes the new data.
- respValid stays high for as many cycles as respReady stays low (back-pressure).
- On the RESP-exit edge, reqReady is 0 in that cycle, so no request is accepted on that edge. The earliest next acceptance is the edge after return to IDLE. Minimum request spacing is LATENCY+2 cycles with respReady held high.
- reqValid while reqReady=0 is ignored. Requesters must hold reqValid until they see reqReady.
- Reset asserted mid-operation, from any state:
  - Outputs take their reset values immediately (asynchronous).
  - A write in WAIT that has not yet committed is discarded.
  - A write already committed remains in memory.

## Test plan
- **Reset:** hold rst=0 for 2 cycles, then release → reqReady=1, respValid=0, readData=0, respError=0, both during and after reset.
- **Write then read:** with LATENCY=2, write 32'hDEADBEEF at address 32'h0000000F&~3 = 32'h0000000C, then read 32'h0000000C → each respValid rises exactly 2 edges after acceptance; write readData=0; read readData=32'hDEADBEEF with respError=0.
- **Back-pressure:** hold respReady=0 for 5 cycles during a read response → respValid and readData stay stable; pulse reqValid during this window → no acceptance (reqReady=0).
- **Errors:** read 32'h0000000F → respError=1, readData=0. Write 32'h00000400 with DEPTH=256 → respError=1; a subsequent read of 32'h00000000 returns the prior contents unchanged.
- **Reset mid-write:** accept a write of 32'h12345678 to 32'h8 (LATENCY=3), drive rst low one cycle later, then read 32'h8 after reset → the old value, not 32'h12345678.
- **Back-to-back:** with LATENCY=1, respReady tied to 1 and reqValid held high → acceptances every 3 cycles; write data at one address then read it back matches.
